mst_strm_gen: RTL

MST_STRM_GEN -- requirements
Module: mst_strm_gen

---
 rtl/mst_strm_gen_pkg.sv | 24 ++
 rtl/mst_strm_chan.sv | 84 ++++++++
 rtl/mst_strm_gen.sv | 64 ++++++
 3 files changed

// File: rtl/mst_strm_gen_pkg.sv
// rtl/mst_strm_gen_pkg.sv - shared mode encodings, LFSR polynomial and seed function
package mst_strm_gen_pkg;

    typedef enum logic [1:0] {
        MODE_INC   = 2'b00,
        MODE_DEC   = 2'b01,
        MODE_PRBS  = 2'b10,
        MODE_CONST = 2'b11
    } gen_mode_e;

    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    // Per-channel seed: channel number in bits [25:24], low bit set so the
    // PRBS sequence never starts from the all-zero lock-up state.
    function automatic logic [31:0] seed_of(input logic [1:0] ch);
        return {6'b0, ch, 24'h000001};
    endfunction

    // One Galois step: shift right, fold the polynomial back in when a 1 falls out.
    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_POLY) : (v >> 1);
    endfunction

endpackage

// File: rtl/mst_strm_chan.sv
// rtl/mst_strm_chan.sv - one generator channel: next-word, output word and word count
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   i_req           one-cycle request for the next word
//   i_mode          pattern select (mst_strm_gen_pkg::gen_mode_e)
//   i_restart       synchronous reload to seed
//   o_dat           registered generated word
//   o_cnt           16-bit words-issued count
// Macro STRM_GEN_PRBS_EN builds the LFSR path; otherwise PRBS mode increments.
module mst_strm_chan
    import mst_strm_gen_pkg::*;
#(
    parameter int DW = 32,
    parameter int CH = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [1:0]    i_mode,
    input  logic          i_restart,
    output logic [DW-1:0] o_dat,
    output logic [15:0]   o_cnt
);

    localparam logic [DW-1:0] SEED = DW'(seed_of(2'(CH)));

    logic [DW-1:0] r_nxt;
    logic [DW-1:0] r_dat;
    logic [15:0]   r_cnt;

    logic [DW-1:0] w_src;
    logic [DW-1:0] w_word;
    logic [DW-1:0] w_nxt_f;
    gen_mode_e     w_mode;

    assign w_mode = gen_mode_e'(i_mode);

    always_comb begin
        // A restart coinciding with a request serves the seed word itself.
        w_src = i_restart ? SEED : r_nxt;
`ifdef STRM_GEN_PRBS_EN
        if (w_mode == MODE_PRBS && w_src == '0) begin
            w_src = SEED;
        end
`endif
        w_word  = w_src;
        w_nxt_f = w_src;
        case (w_mode)
            MODE_INC:   w_nxt_f = w_src + DW'(1);
            MODE_DEC:   w_nxt_f = w_src - DW'(1);
`ifdef STRM_GEN_PRBS_EN
            MODE_PRBS:  w_nxt_f = DW'(lfsr_next(32'(w_src)));
`else
            MODE_PRBS:  w_nxt_f = w_src + DW'(1);
`endif
            MODE_CONST: begin
                w_word  = SEED;
                w_nxt_f = w_src;
            end
            default:    w_nxt_f = w_src;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_nxt <= SEED;
            r_dat <= SEED;
            r_cnt <= '0;
        end else if (i_req) begin
            r_dat <= w_word;
            r_nxt <= w_nxt_f;
            r_cnt <= i_restart ? 16'd1 : r_cnt + 16'd1;
        end else if (i_restart) begin
            r_nxt <= SEED;
            r_dat <= SEED;
            r_cnt <= '0;
        end
    end

    assign o_dat = r_dat;
    assign o_cnt = r_cnt;

endmodule

// File: rtl/mst_strm_gen.sv
// rtl/mst_strm_gen.sv - four-channel test-pattern stream generator
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   gen0req..gen3req      per-channel word request pulses
//   gen0dat..gen3dat      per-channel registered generated words (WIDTH-4 bits)
//   genmode               00 inc, 01 dec, 10 PRBS, 11 constant
//   restart               synchronous reload of all channels to their seeds
//   cntsel, wcnt          word-count readback select and value
// Macro STRM_GEN_PRBS_EN enables the LFSR pattern; without it PRBS acts as increment.
module mst_strm_gen
    import mst_strm_gen_pkg::*;
#(
    parameter int WIDTH = 36
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               gen0req,
    input  logic               gen1req,
    input  logic               gen2req,
    input  logic               gen3req,
    output logic [WIDTH-5:0]   gen0dat,
    output logic [WIDTH-5:0]   gen1dat,
    output logic [WIDTH-5:0]   gen2dat,
    output logic [WIDTH-5:0]   gen3dat,
    input  logic [1:0]         genmode,
    input  logic               restart,
    input  logic [1:0]         cntsel,
    output logic [15:0]        wcnt
);

    localparam int DW = WIDTH - 4;

    logic [15:0] w_cnt0, w_cnt1, w_cnt2, w_cnt3;

    mst_strm_chan #(.DW(DW), .CH(0)) u_chan0 (
        .clk(clk), .rst(rst), .i_req(gen0req), .i_mode(genmode),
        .i_restart(restart), .o_dat(gen0dat), .o_cnt(w_cnt0)
    );
    mst_strm_chan #(.DW(DW), .CH(1)) u_chan1 (
        .clk(clk), .rst(rst), .i_req(gen1req), .i_mode(genmode),
        .i_restart(restart), .o_dat(gen1dat), .o_cnt(w_cnt1)
    );
    mst_strm_chan #(.DW(DW), .CH(2)) u_chan2 (
        .clk(clk), .rst(rst), .i_req(gen2req), .i_mode(genmode),
        .i_restart(restart), .o_dat(gen2dat), .o_cnt(w_cnt2)
    );
    mst_strm_chan #(.DW(DW), .CH(3)) u_chan3 (
        .clk(clk), .rst(rst), .i_req(gen3req), .i_mode(genmode),
        .i_restart(restart), .o_dat(gen3dat), .o_cnt(w_cnt3)
    );

    always_comb begin
        wcnt = w_cnt0;
        case (cntsel)
            2'd0:    wcnt = w_cnt0;
            2'd1:    wcnt = w_cnt1;
            2'd2:    wcnt = w_cnt2;
            2'd3:    wcnt = w_cnt3;
            default: wcnt = w_cnt0;
        endcase
    end

endmodule
